// File: rtl/io_isol_pkg.sv
// rtl/io_isol_pkg.sv - shared types and widths for the I/O isolation sequencer
package io_isol_pkg;

  typedef enum logic [1:0] {
    ISOLATED = 2'd0,
    SETTLE   = 2'd1,
    RELEASE  = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  localparam int ABORT_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, asynchronous active-high reset to 0
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_isol_sequencer.sv
// rtl/io_isol_sequencer.sv - holds I/O groups isolated until config settles,
// then releases them one by one; re-isolates all groups on loss of config or request
module io_isol_sequencer
  import io_isol_pkg::*;
#(
  parameter int NUM_GROUPS     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_done,
  input  logic                   isol_req,
  output logic [NUM_GROUPS-1:0]  IO_ISOL_N,
  output logic                   io_ready,
  output logic                   seq_busy,
  output logic [ABORT_CNT_W-1:0] abort_cnt
);

  localparam int IDX_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  // A zero settle time still spends one cycle in SETTLE.
  localparam int SETTLE_LAST  = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int STAGGER_LAST = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;

  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("io_isol_sequencer: STAGGER_CYCLES must be at least 1");
  end

  logic cfg_s, req_s, go;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_GROUPS-1:0] isol_d;
  logic [ABORT_CNT_W-1:0] abort_d;

  sync_2ff u_sync_cfg (.clk(clk), .reset(reset), .d(cfg_done), .q(cfg_s));
  sync_2ff u_sync_req (.clk(clk), .reset(reset), .d(isol_req), .q(req_s));

  assign go = cfg_s & ~req_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ISOLATED;
      cnt_q     <= '0;
      idx_q     <= '0;
      IO_ISOL_N <= '0;
      abort_cnt <= '0;
      io_ready  <= 1'b0;
      seq_busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      IO_ISOL_N <= isol_d;
      abort_cnt <= abort_d;
      io_ready  <= (state_d == ACTIVE);
      seq_busy  <= (state_d == SETTLE) || (state_d == RELEASE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    isol_d  = IO_ISOL_N;
    abort_d = abort_cnt;

    case (state_q)
      ISOLATED: begin
        isol_d = '0;
        if (go) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          cnt_d     = '0;
          idx_d     = '0;
          isol_d    = '0;
          isol_d[0] = 1'b1;
          state_d   = (NUM_GROUPS == 1) ? ACTIVE : RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_LAST)) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          for (int i = 1; i < NUM_GROUPS; i++) begin
            if (i == int'(idx_q) + 1) isol_d[i] = 1'b1;
          end
          if (int'(idx_q) + 2 == NUM_GROUPS) state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        isol_d = '1;
      end
    endcase

    // Loss of go overrides any counting or release on the same edge.
    if ((state_q != ISOLATED) && !go) begin
      state_d = ISOLATED;
      cnt_d   = '0;
      idx_d   = '0;
      isol_d  = '0;
      if ((state_q != ACTIVE) && (abort_cnt != '1)) abort_d = abort_cnt + ABORT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_io_isol_sequencer.sv
// tb/tb_io_isol_sequencer.sv - directed scoreboard bench for io_isol_sequencer
module tb_io_isol_sequencer;

  logic clk = 1'b0;
  logic reset, cfg_done, isol_req, cfg_done2;
  logic [3:0] isol1;
  logic [0:0] isol2;
  logic ready1, busy1, ready2, busy2;
  logic [7:0] abort1, abort2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0, r0;

  typedef struct {
    int         due;
    bit         d2;
    logic [3:0] isol;
    logic       ready;
    logic       busy;
    logic [7:0] ab;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  io_isol_sequencer #(.NUM_GROUPS(4), .SETTLE_CYCLES(16), .STAGGER_CYCLES(4), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .cfg_done(cfg_done), .isol_req(isol_req),
    .IO_ISOL_N(isol1), .io_ready(ready1), .seq_busy(busy1), .abort_cnt(abort1)
  );

  io_isol_sequencer #(.NUM_GROUPS(1), .SETTLE_CYCLES(0), .STAGGER_CYCLES(4), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .cfg_done(cfg_done2), .isol_req(1'b0),
    .IO_ISOL_N(isol2), .io_ready(ready2), .seq_busy(busy2), .abort_cnt(abort2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int due, input bit d2, input logic [3:0] isol, input logic ready,
                      input logic busy, input logic [7:0] ab, input string tag);
    exp_t e;
    e.due = due; e.d2 = d2; e.isol = isol; e.ready = ready; e.busy = busy; e.ab = ab; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "_due"}, 32'(cyc), 32'(e.due));
      if (e.d2) begin
        chk({e.tag, "_isol"},  32'({3'b000, isol2}), 32'(e.isol));
        chk({e.tag, "_ready"}, 32'(ready2), 32'(e.ready));
        chk({e.tag, "_busy"},  32'(busy2), 32'(e.busy));
        chk({e.tag, "_abort"}, 32'(abort2), 32'(e.ab));
      end else begin
        chk({e.tag, "_isol"},  32'(isol1), 32'(e.isol));
        chk({e.tag, "_ready"}, 32'(ready1), 32'(e.ready));
        chk({e.tag, "_busy"},  32'(busy1), 32'(e.busy));
        chk({e.tag, "_abort"}, 32'(abort1), 32'(e.ab));
      end
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  initial begin
    reset = 1'b1; cfg_done = 1'b0; isol_req = 1'b0; cfg_done2 = 1'b0;
    #1;
    chk("rst_isol", 32'(isol1), 32'h0);
    chk("rst_ready", 32'(ready1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_abort", 32'(abort1), 32'h0);
    chk("rst_isol2", 32'(isol2), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Full release sequence with default timing
    e0 = cyc + 1; cfg_done = 1'b1;
    push(e0 + 1,  0, 4'b0000, 0, 0, 8'd0, "t1_e1");
    push(e0 + 2,  0, 4'b0000, 0, 1, 8'd0, "t1_e2");
    push(e0 + 17, 0, 4'b0000, 0, 1, 8'd0, "t1_e17");
    push(e0 + 18, 0, 4'b0001, 0, 1, 8'd0, "t1_e18");
    push(e0 + 21, 0, 4'b0001, 0, 1, 8'd0, "t1_e21");
    push(e0 + 22, 0, 4'b0011, 0, 1, 8'd0, "t1_e22");
    push(e0 + 26, 0, 4'b0111, 0, 1, 8'd0, "t1_e26");
    push(e0 + 29, 0, 4'b0111, 0, 1, 8'd0, "t1_e29");
    push(e0 + 30, 0, 4'b1111, 1, 0, 8'd0, "t1_e30");
    push(e0 + 34, 0, 4'b1111, 1, 0, 8'd0, "t1_e34");
    run_to(e0 + 35);

    // Abort in SETTLE by dropping cfg_done after E10
    reset = 1'b1; cfg_done = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    e0 = cyc + 1; cfg_done = 1'b1;
    push(e0 + 12, 0, 4'b0000, 0, 1, 8'd0, "t2_e12");
    push(e0 + 13, 0, 4'b0000, 0, 0, 8'd1, "t2_e13");
    push(e0 + 15, 0, 4'b0000, 0, 0, 8'd1, "t2_e15");
    run_to(e0 + 10);
    cfg_done = 1'b0;
    run_to(e0 + 16);
    e0 = cyc + 1; cfg_done = 1'b1;
    push(e0 + 17, 0, 4'b0000, 0, 1, 8'd1, "t2r_e17");
    push(e0 + 18, 0, 4'b0001, 0, 1, 8'd1, "t2r_e18");
    push(e0 + 30, 0, 4'b1111, 1, 0, 8'd1, "t2r_e30");
    run_to(e0 + 31);

    // isol_req from ACTIVE: isolated 3 edges later, abort count unchanged
    e0 = cyc + 1; isol_req = 1'b1;
    push(e0 + 1, 0, 4'b1111, 1, 0, 8'd1, "t4_hold");
    push(e0 + 2, 0, 4'b0000, 0, 0, 8'd1, "t4_iso");
    run_to(e0 + 5);

    // isol_req pulse during RELEASE, then rerun
    e0 = cyc + 1; isol_req = 1'b0;
    push(e0 + 22, 0, 4'b0011, 0, 1, 8'd1, "t3_e22");
    push(e0 + 24, 0, 4'b0011, 0, 1, 8'd1, "t3_e24");
    push(e0 + 25, 0, 4'b0000, 0, 0, 8'd2, "t3_abort");
    run_to(e0 + 22);
    isol_req = 1'b1;
    run_to(e0 + 23);
    isol_req = 1'b0;
    r0 = cyc;
    push(r0 + 30, 0, 4'b0111, 0, 1, 8'd2, "t3_r30");
    push(r0 + 31, 0, 4'b1111, 1, 0, 8'd2, "t3_r31");
    run_to(r0 + 33);

    // Asynchronous reset between edges while in RELEASE
    isol_req = 1'b1;
    run_to(cyc + 4);
    chk("t5_abort_before", 32'(abort1), 32'd2);
    isol_req = 1'b0;
    e0 = cyc + 1;
    push(e0 + 22, 0, 4'b0011, 0, 1, 8'd2, "t5_pre");
    run_to(e0 + 23);
    #2 reset = 1'b1;
    #1;
    chk("t5_isol", 32'(isol1), 32'h0);
    chk("t5_ready", 32'(ready1), 32'h0);
    chk("t5_busy", 32'(busy1), 32'h0);
    chk("t5_abort", 32'(abort1), 32'h0);

    // Forced aborts from SETTLE: count then saturate
    isol_req = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int n = 0; n < 10; n++) begin
      isol_req = 1'b0; run_to(cyc + 4);
      isol_req = 1'b1; run_to(cyc + 4);
    end
    chk("t6_abort10", 32'(abort1), 32'd10);
    for (int n = 0; n < 290; n++) begin
      isol_req = 1'b0; run_to(cyc + 4);
      isol_req = 1'b1; run_to(cyc + 4);
    end
    chk("t6_abort_sat", 32'(abort1), 32'd255);
    chk("t6_isol", 32'(isol1), 32'h0);

    // Single-group, zero-settle instance: uncaptured glitch, then real release
    tick();
    #1 cfg_done2 = 1'b1;
    #3 cfg_done2 = 1'b0;
    run_to(cyc + 6);
    chk("t7_glitch_isol", 32'(isol2), 32'h0);
    chk("t7_glitch_ready", 32'(ready2), 32'h0);
    chk("t7_glitch_busy", 32'(busy2), 32'h0);
    e0 = cyc + 1; cfg_done2 = 1'b1;
    push(e0 + 2, 1, 4'b0000, 0, 1, 8'd0, "t7_e2");
    push(e0 + 3, 1, 4'b0001, 1, 0, 8'd0, "t7_e3");
    push(e0 + 6, 1, 4'b0001, 1, 0, 8'd0, "t7_e6");
    run_to(e0 + 7);

    while (sb.size() > 0) begin
      chk({sb[0].tag, "_never_reached"}, 32'(cyc), 32'(sb[0].due));
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
